wb_sram_multi_interface: RTL and testbench

- Parametrised Wishbone-classic slave bridging one core-side bus to TARGETS local memory-like targets (SRAM banks, management port, peripheral windows).
- Decodes the target from the upper address bits and latches the full request, including address, select and write data.
- Drives one target at a time with single-access handshakes and returns a registered read word.
- Adds unmapped-address error, busy timeout error and cycle-abort handling; replaces fixed two-target bridges in each core.

---
 rtl/wb_sram_multi_interface.sv | 186 ++++++++++++++++++
 tb/tb_wb_sram_multi_interface.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_multi_interface.sv
// Wishbone-classic slave fanning one bus out to TARGETS memory-like ports.
// Latches each request, runs one target handshake, returns ack/error pulses.
module wb_sram_multi_interface #(
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 32,
   parameter int TARGETS        = 2,
   parameter int SEL_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_i,
   input  logic                             wb_cyc_i,
   input  logic                             wb_stb_i,
   input  logic                             wb_we_i,
   input  logic [DATA_WIDTH/8-1:0]          wb_sel_i,
   input  logic [DATA_WIDTH-1:0]            wb_data_i,
   input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
   output logic                             wb_ack_o,
   output logic                             wb_stall_o,
   output logic                             wb_error_o,
   output logic [DATA_WIDTH-1:0]            wb_data_o,
   output logic [ADDR_WIDTH-SEL_BITS-1:0]   tgt_address,
   output logic [DATA_WIDTH/8-1:0]          tgt_byteSelect,
   output logic [DATA_WIDTH-1:0]            tgt_writeData,
   output logic [TARGETS-1:0]               tgt_writeEnable,
   output logic [TARGETS-1:0]               tgt_readEnable,
   input  logic [TARGETS*DATA_WIDTH-1:0]    tgt_readData,
   input  logic [TARGETS-1:0]               tgt_busy
);

   localparam int OW = ADDR_WIDTH - SEL_BITS;
   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
   localparam logic [SEL_BITS:0] NTGT = (SEL_BITS + 1)'(TARGETS);

   typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_e;

   state_e                state_q, state_d;
   logic [OW-1:0]         off_q, off_d;
   logic [BW-1:0]         sel_q, sel_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic                  we_q, we_d;
   logic [SEL_BITS-1:0]   idx_q, idx_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  stall_q, stall_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  abort_q, abort_d;

   logic [DATA_WIDTH-1:0] rd_sel;
   logic                  busy_sel;
   logic [CW-1:0]         cnt_inc;
   logic                  timeout;
   logic                  mapped;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         off_q   <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         stall_q <= 1'b0;
         rdat_q  <= '1;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         stall_q <= stall_d;
         rdat_q  <= rdat_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   // Target selection is driven only by the latched index.
   always_comb begin
      rd_sel   = '0;
      busy_sel = 1'b0;
      for (int k = 0; k < TARGETS; k++) begin
         if (idx_q == SEL_BITS'(k)) begin
            rd_sel   = tgt_readData[k*DATA_WIDTH +: DATA_WIDTH];
            busy_sel = tgt_busy[k];
         end
      end
   end

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMAX);
   assign mapped  = {1'b0, wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS]} < NTGT;

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      we_d    = we_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      stall_d = stall_q;
      rdat_d  = rdat_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      unique case (state_q)
         IDLE: begin
            stall_d = 1'b0;
            rdat_d  = '1;
            cnt_d   = '0;
            abort_d = 1'b0;
            if (wb_cyc_i && wb_stb_i) begin
               off_d   = wb_adr_i[OW-1:0];
               sel_d   = wb_sel_i;
               wdat_d  = wb_data_i;
               we_d    = wb_we_i;
               idx_d   = wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS];
               stall_d = 1'b1;
               if (mapped) begin
                  state_d = ACCESS;
               end else begin
                  state_d = FINISH;
                  err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            // A dropped cycle still lets the target finish, but silently.
            abort_d = abort_q | ~wb_cyc_i;
            if (!busy_sel) begin
               state_d = FINISH;
               ack_d   = ~abort_d;
               if (!we_q) rdat_d = rd_sel;
            end else begin
               cnt_d = cnt_inc;
               if (timeout) begin
                  state_d = FINISH;
                  err_d   = ~abort_d;
                  rdat_d  = '1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            stall_d = 1'b0;
            rdat_d  = '1;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tgt_writeEnable = '0;
      tgt_readEnable  = '0;
      tgt_address     = '0;
      tgt_byteSelect  = '0;
      tgt_writeData   = '0;
      if (state_q == ACCESS) begin
         tgt_address    = off_q;
         tgt_byteSelect = sel_q;
         tgt_writeData  = wdat_q;
         for (int k = 0; k < TARGETS; k++) begin
            tgt_writeEnable[k] = we_q & (idx_q == SEL_BITS'(k));
            tgt_readEnable[k]  = ~we_q & (idx_q == SEL_BITS'(k));
         end
      end
   end

   assign wb_ack_o   = ack_q;
   assign wb_error_o = err_q;
   assign wb_stall_o = stall_q;
   assign wb_data_o  = rdat_q;

endmodule

// File: tb/tb_wb_sram_multi_interface.sv
// Directed-vector bench for wb_sram_multi_interface (TARGETS=2, timeout 4).
module tb_wb_sram_multi_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] wdat;
   logic [23:0] adr;
   logic        ack, stall, err;
   logic [31:0] rdat;
   logic [19:0] t_adr;
   logic [3:0]  t_sel;
   logic [31:0] t_wdat;
   logic [1:0]  t_we, t_re;
   logic [63:0] t_rdat;
   logic [1:0]  t_busy;

   int n_tests = 0;
   int n_fail  = 0;

   wb_sram_multi_interface #(
      .ADDR_WIDTH(24), .DATA_WIDTH(32), .TARGETS(2),
      .SEL_BITS(4), .TIMEOUT_CYCLES(4)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_sel_i(sel), .wb_data_i(wdat), .wb_adr_i(adr),
      .wb_ack_o(ack), .wb_stall_o(stall), .wb_error_o(err),
      .wb_data_o(rdat),
      .tgt_address(t_adr), .tgt_byteSelect(t_sel),
      .tgt_writeData(t_wdat), .tgt_writeEnable(t_we),
      .tgt_readEnable(t_re), .tgt_readData(t_rdat),
      .tgt_busy(t_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic [23:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
   endtask

   initial begin
      rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0;
      wdat = 0; adr = 0; t_busy = 0; t_rdat = 0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_data", rdat, 32'hFFFFFFFF);
      chk("rst_en", {t_we, t_re}, 0);
      chk("rst_adr", t_adr, 0);

      // write to target 0, live inputs changed after accept
      req(1, 24'h000010, 32'hDEADBEEF, 4'hF);
      step();
      stb = 0; adr = 24'h1ABCDE; wdat = 32'h0; sel = 4'h0;
      chk("wr_we", t_we, 2'b01);
      chk("wr_re", t_re, 2'b00);
      chk("wr_adr", t_adr, 20'h00010);
      chk("wr_data", t_wdat, 32'hDEADBEEF);
      chk("wr_sel", t_sel, 4'hF);
      chk("wr_stall", stall, 1);
      chk("wr_ack_early", ack, 0);
      step();
      chk("wr_ack", ack, 1);
      chk("wr_err", err, 0);
      chk("wr_we_off", t_we, 0);
      chk("wr_adr_off", t_adr, 0);
      step();
      cyc = 0;
      chk("wr_ack_drop", ack, 0);
      chk("wr_stall_drop", stall, 0);

      // read from target 1, busy for three cycles
      t_rdat = {32'h12345678, 32'hA5A5A5A5};
      t_busy = 2'b10;
      req(0, 24'h100004, 32'h0, 4'hF);
      step();
      stb = 0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) t_busy = 2'b00;
         chk($sformatf("rd_re%0d", i), t_re, 2'b10);
         chk($sformatf("rd_ack%0d", i), ack, 0);
         if (i == 1) chk("rd_adr", t_adr, 20'h00004);
         step();
      end
      chk("rd_ack", ack, 1);
      chk("rd_data", rdat, 32'h12345678);
      chk("rd_re_off", t_re, 0);
      step();
      cyc = 0;
      chk("rd_ack_drop", ack, 0);
      chk("rd_data_idle", rdat, 32'hFFFFFFFF);

      // unmapped index
      req(0, 24'hF00000, 32'h0, 4'hF);
      step();
      stb = 0;
      chk("um_err", err, 1);
      chk("um_ack", ack, 0);
      chk("um_en", {t_we, t_re}, 0);
      chk("um_data", rdat, 32'hFFFFFFFF);
      step();
      cyc = 0;
      chk("um_err_drop", err, 0);

      // timeout with busy stuck
      t_busy = 2'b01;
      req(1, 24'h000020, 32'h55AA55AA, 4'h3);
      step();
      stb = 0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("to_we%0d", i), t_we, 2'b01);
         chk($sformatf("to_err%0d", i), err, 0);
         step();
      end
      chk("to_err", err, 1);
      chk("to_ack", ack, 0);
      chk("to_we_off", t_we, 0);
      chk("to_data", rdat, 32'hFFFFFFFF);
      step();
      cyc = 0;
      chk("to_err_drop", err, 0);
      t_busy = 2'b00;
      req(1, 24'h000024, 32'h01020304, 4'hF);
      step();
      stb = 0;
      chk("to_next_we", t_we, 2'b01);
      chk("to_next_adr", t_adr, 20'h00024);
      step();
      chk("to_next_ack", ack, 1);
      step();
      cyc = 0;

      // abort: cycle dropped during busy read
      t_busy = 2'b10;
      t_rdat = {32'hCAFEF00D, 32'h0};
      req(0, 24'h100008, 32'h0, 4'hF);
      step();
      cyc = 0; stb = 0;
      chk("ab_re1", t_re, 2'b10);
      step();
      chk("ab_re2", t_re, 2'b10);
      t_busy = 2'b00;
      step();
      chk("ab_ack", ack, 0);
      chk("ab_err", err, 0);
      chk("ab_re_off", t_re, 0);
      step();
      chk("ab_stall", stall, 0);

      // reset in the middle of an access
      t_busy = 2'b01;
      req(1, 24'h000030, 32'h11111111, 4'hF);
      step();
      stb = 0;
      chk("rs_we", t_we, 2'b01);
      rst = 1'b1;
      step();
      chk("rs_en", {t_we, t_re}, 0);
      chk("rs_stall", stall, 0);
      chk("rs_ack", ack, 0);
      rst = 1'b0; cyc = 0; t_busy = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
